// File: rtl/button_event_controller.sv
// Turns debounced button levels into registered one-cycle press/release/long-press pulses.
// Optional macro BTN_AUTO_REPEAT_EN adds the HELD auto-repeat counter and repeat_pulse.
module button_event_controller #(
   parameter int unsigned BUS_WIDTH  = 1,
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned LONG_MS    = 1000,
   parameter int unsigned REPEAT_MS  = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] btn_db,
   output logic [BUS_WIDTH-1:0] press_pulse,
   output logic [BUS_WIDTH-1:0] release_pulse,
   output logic [BUS_WIDTH-1:0] long_pulse,
   output logic [BUS_WIDTH-1:0] repeat_pulse,
   output logic [BUS_WIDTH-1:0] held
);

   localparam int unsigned   DIV       = CLOCK_FREQ / 1000;
   localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam int unsigned   CNT_MAX   = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int unsigned   CW        = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_MS - 1);
`endif

   typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

   logic [PW-1:0]        presc;
   logic                 tick_ms;
   logic [BUS_WIDTH-1:0] btn_q;
   logic [BUS_WIDTH-1:0] rise;
   logic [BUS_WIDTH-1:0] fall;
   state_t               state  [BUS_WIDTH];
   logic [CW-1:0]        ms_cnt [BUS_WIDTH];

   // Shared 1 ms timebase, free-running regardless of button activity
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
      end else if (presc == PRESC_MAX) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign tick_ms = (presc == PRESC_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q <= '0;
      end else begin
         btn_q <= btn_db;
      end
   end

   assign rise = btn_db & ~btn_q;
   assign fall = ~btn_db & btn_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
            state[i]  <= IDLE;
            ms_cnt[i] <= '0;
         end
         press_pulse   <= '0;
         release_pulse <= '0;
         long_pulse    <= '0;
         held          <= '0;
`ifdef BTN_AUTO_REPEAT_EN
         repeat_pulse  <= '0;
`endif
      end else begin
         press_pulse   <= '0;
         release_pulse <= '0;
         long_pulse    <= '0;
`ifdef BTN_AUTO_REPEAT_EN
         repeat_pulse  <= '0;
`endif
         for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
            unique case (state[i])
               IDLE: begin
                  if (rise[i]) begin
                     state[i]       <= PRESS;
                     press_pulse[i] <= 1'b1;
                     held[i]        <= 1'b1;
                     ms_cnt[i]      <= '0;
                  end
               end
               // Release takes priority over a tick landing in the same cycle
               PRESS: begin
                  if (fall[i]) begin
                     state[i]         <= IDLE;
                     release_pulse[i] <= 1'b1;
                     held[i]          <= 1'b0;
                  end else if (tick_ms) begin
                     if (ms_cnt[i] >= LONG_LAST) begin
                        state[i]      <= HELD;
                        long_pulse[i] <= 1'b1;
                        ms_cnt[i]     <= '0;
                     end else if (ms_cnt[i] != CNT_SAT) begin
                        ms_cnt[i] <= ms_cnt[i] + 1'b1;
                     end
                  end
               end
               HELD: begin
                  if (fall[i]) begin
                     state[i]         <= IDLE;
                     release_pulse[i] <= 1'b1;
                     held[i]          <= 1'b0;
                  end
`ifdef BTN_AUTO_REPEAT_EN
                  else if (tick_ms) begin
                     if (ms_cnt[i] >= REP_LAST) begin
                        repeat_pulse[i] <= 1'b1;
                        ms_cnt[i]       <= '0;
                     end else if (ms_cnt[i] != CNT_SAT) begin
                        ms_cnt[i] <= ms_cnt[i] + 1'b1;
                     end
                  end
`endif
               end
               default: begin
                  state[i] <= IDLE;
                  held[i]  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifndef BTN_AUTO_REPEAT_EN
   assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_button_event_controller.sv
// Bench for button_event_controller: vector table, directed corner sequences and random
// stimulus against an arithmetic event-time model (10 clk/ms, LONG_MS=3, REPEAT_MS=2).
module tb_button_event_controller;

   localparam int unsigned BW   = 2;
   localparam int          TPM  = 10;
   localparam int          LONG = 3;
   localparam int          REP  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] btn_db;
   logic [BW-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset, last sampled levels, press status, scheduled long edge
   int         edge_no;
   logic [1:0] lvl, pressed;
   int         long_edge [2];
   logic [1:0] e_press, e_rel, e_long, e_rep, e_held;

   typedef struct {
      logic [1:0] b;
      logic       r;
      logic [1:0] p, rl, lg, h;
   } vec_t;
   vec_t vecs[$];

   int n_long, off_long, n_rep, last_rep, bad_gap, target, n_long1;
   logic [1:0] rb;

   button_event_controller #(
      .BUS_WIDTH (BW),
      .CLOCK_FREQ(10_000),
      .LONG_MS   (LONG),
      .REPEAT_MS (REP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_db       (btn_db),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held)
   );

   always #5 clk = ~clk;

   // Tick edges are every TPM-th edge after reset; long edge is the LONG-th tick after press
   function automatic void model_edge(logic [1:0] b, logic r);
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
      if (!r) begin
         edge_no = 0;
         lvl     = '0;
         pressed = '0;
         e_held  = '0;
         return;
      end
      edge_no++;
      for (int i = 0; i < 2; i++) begin
         if (!pressed[i] && b[i] && !lvl[i]) begin
            pressed[i]   = 1'b1;
            e_press[i]   = 1'b1;
            long_edge[i] = (edge_no / TPM + LONG) * TPM;
         end else if (pressed[i] && !b[i]) begin
            pressed[i] = 1'b0;
            e_rel[i]   = 1'b1;
         end else if (pressed[i]) begin
            if (edge_no == long_edge[i]) e_long[i] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            else if (edge_no > long_edge[i] && (edge_no - long_edge[i]) % (TPM * REP) == 0)
               e_rep[i] = 1'b1;
`endif
         end
      end
      lvl    = b;
      e_held = pressed;
   endfunction

   task automatic check_model();
      checks++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !==
          {e_press, e_rel, e_long, e_rep, e_held}) begin
         errors++;
         $display("FAIL model edge=%0d got p/r/l/rp/h=%b/%b/%b/%b/%b exp=%b/%b/%b/%b/%b",
                  edge_no, press_pulse, release_pulse, long_pulse, repeat_pulse, held,
                  e_press, e_rel, e_long, e_rep, e_held);
      end
   endtask

   task automatic expect_eq(string tag, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Called at a negedge: drive, let one rising edge happen, then compare 1 time unit later
   task automatic cycle(logic [1:0] b, logic r);
      btn_db = b;
      rst    = r;
      @(posedge clk);
      model_edge(b, r);
      #1 check_model();
      @(negedge clk);
   endtask

   function automatic void add(logic [1:0] b, logic r, logic [1:0] p, logic [1:0] rl,
                               logic [1:0] lg, logic [1:0] h);
      vec_t v;
      v.b = b; v.r = r; v.p = p; v.rl = rl; v.lg = lg; v.h = h;
      vecs.push_back(v);
   endfunction

   initial begin
      rst    = 1'b0;
      btn_db = '0;
      model_edge(2'b00, 1'b0);

      //   btn    rst   press  rel    long   held
      for (int i = 0; i < 5; i++) add(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01);
      for (int i = 0; i < 3; i++) add(2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
      add(2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
      add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
      add(2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 2'b11);
      add(2'b01, 1'b1, 2'b00, 2'b10, 2'b00, 2'b01);
      add(2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
      add(2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01);
      add(2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
      add(2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01);
      add(2'b00, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].b, vecs[i].r);
         checks++;
         if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !==
             {vecs[i].p, vecs[i].rl, vecs[i].lg, 2'b00, vecs[i].h}) begin
            errors++;
            $display("FAIL table row=%0d got p/r/l/rp/h=%b/%b/%b/%b/%b exp=%b/%b/%b/00/%b",
                     i, press_pulse, release_pulse, long_pulse, repeat_pulse, held,
                     vecs[i].p, vecs[i].rl, vecs[i].lg, vecs[i].h);
         end
      end

      // Short press: 15 clk, no long pulse
      cycle(2'b00, 1'b1);
      cycle(2'b01, 1'b1);
      expect_eq("short_press", int'(press_pulse), 1);
      n_long = 0;
      for (int j = 1; j < 15; j++) begin
         cycle(2'b01, 1'b1);
         if (long_pulse[0]) n_long++;
         if (!held[0]) n_long += 100;
      end
      expect_eq("short_no_long_held", n_long, 0);
      cycle(2'b00, 1'b1);
      expect_eq("short_release", int'(release_pulse), 1);

      // Long press: 120 clk
      cycle(2'b00, 1'b1);
      cycle(2'b01, 1'b1);
      expect_eq("long_press", int'(press_pulse), 1);
      n_long = 0; off_long = -1; n_rep = 0; last_rep = -1; bad_gap = 0;
      for (int j = 1; j < 120; j++) begin
         cycle(2'b01, 1'b1);
         if (long_pulse[0]) begin
            n_long++;
            off_long = j;
         end
         if (repeat_pulse[0]) begin
            if (((last_rep < 0) ? j - off_long : j - last_rep) != TPM * REP) bad_gap++;
            n_rep++;
            last_rep = j;
         end
      end
      expect_eq("long_count", n_long, 1);
      checks++;
      if (off_long < 21 || off_long > 30) begin
         errors++;
         $display("FAIL long_offset got=%0d exp=21..30", off_long);
      end
`ifdef BTN_AUTO_REPEAT_EN
      expect_eq("repeat_count", n_rep, (119 - off_long) / (TPM * REP));
      expect_eq("repeat_gap", bad_gap, 0);
`else
      expect_eq("repeat_count", n_rep, 0);
`endif
      cycle(2'b00, 1'b1);
      expect_eq("long_release", int'(release_pulse), 1);

      // Release sampled on the edge that registers the LONG-th tick
      cycle(2'b00, 1'b1);
      cycle(2'b01, 1'b1);
      target = long_edge[0];
      while (edge_no + 1 < target) cycle(2'b01, 1'b1);
      cycle(2'b00, 1'b1);
      expect_eq("tick_release", int'(release_pulse), 1);
      expect_eq("tick_no_long", int'(long_pulse), 0);

      // Concurrent press, button 1 released early
      cycle(2'b00, 1'b1);
      cycle(2'b11, 1'b1);
      expect_eq("conc_press", int'(press_pulse), 3);
      for (int j = 0; j < 10; j++) cycle(2'b11, 1'b1);
      cycle(2'b01, 1'b1);
      expect_eq("conc_release1", int'(release_pulse), 2);
      expect_eq("conc_held", int'(held), 1);
      n_long = 0; n_long1 = 0;
      for (int j = 0; j < 40; j++) begin
         cycle(2'b01, 1'b1);
         if (long_pulse[0]) n_long++;
         if (long_pulse[1]) n_long1++;
      end
      expect_eq("conc_long0", n_long, 1);
      expect_eq("conc_long1", n_long1, 0);
      cycle(2'b00, 1'b1);
      expect_eq("conc_release0", int'(release_pulse), 1);

      // Reset mid-hold, button kept pressed through reset
      cycle(2'b00, 1'b1);
      cycle(2'b01, 1'b1);
      for (int j = 0; j < 35; j++) cycle(2'b01, 1'b1);
      expect_eq("hold_before_rst", int'(held), 1);
      btn_db = 2'b01;
      rst    = 1'b0;
      #1;
      expect_eq("rst_async_outputs",
                int'({press_pulse, release_pulse, long_pulse, repeat_pulse, held}), 0);
      @(posedge clk);
      model_edge(2'b01, 1'b0);
      #1 check_model();
      @(negedge clk);
      for (int j = 0; j < 3; j++) cycle(2'b01, 1'b0);
      cycle(2'b01, 1'b1);
      expect_eq("press_after_rst", int'(press_pulse), 1);

      // Random: slow-changing buttons, occasional reset
      rb = 2'b01;
      for (int j = 0; j < 3000; j++) begin
         for (int k = 0; k < 2; k++)
            if ($urandom_range(39) == 0) rb[k] = ~rb[k];
         cycle(rb, ($urandom_range(499) != 0));
      end

      cycle(2'b00, 1'b1);
      cycle(2'b00, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
